// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory request
// in flight and drives the IF/ID register, parking a stalled return in a depth-1 buffer.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, r_imem_addr, r_id_pc, r_id_inst, r_hold_pc, r_hold_inst;
    logic        r_imem_req, r_id_valid;

    logic        w_ack;
    logic [31:0] w_redirect, w_pc_plus4, w_issue_addr;
    logic        w_issue, w_req_clr, w_pc_inc, w_pc_redirect;
    logic        w_hold_load, w_id_fetch, w_id_hold, w_id_bubble;

    assign w_ack      = imem_ack_i & r_imem_req;
    assign w_redirect = redirect_pc_i & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_pc + 32'd4;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: w_state_next = S_REQ;
            S_REQ: begin
                if (flush_i)              w_state_next = w_ack ? S_REQ : S_DROP;
                else if (w_ack && stall_i) w_state_next = S_HOLD;
            end
            S_HOLD: if (flush_i || !stall_i) w_state_next = S_REQ;
            S_DROP: if (w_ack) w_state_next = S_REQ;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue       = 1'b0;
        w_issue_addr  = r_pc;
        w_req_clr     = 1'b0;
        w_pc_inc      = 1'b0;
        w_pc_redirect = 1'b0;
        w_hold_load   = 1'b0;
        w_id_fetch    = 1'b0;
        w_id_hold     = 1'b0;
        w_id_bubble   = 1'b0;
        case (r_state)
            S_IDLE: w_issue = 1'b1;
            S_REQ: begin
                if (flush_i) begin
                    w_id_bubble   = 1'b1;
                    w_pc_redirect = 1'b1;
                    w_issue       = w_ack;
                    w_issue_addr  = w_redirect;
                end else if (w_ack && !stall_i) begin
                    w_id_fetch   = 1'b1;
                    w_pc_inc     = 1'b1;
                    w_issue      = 1'b1;
                    w_issue_addr = w_pc_plus4;
                end else if (w_ack) begin
                    w_hold_load = 1'b1;
                    w_req_clr   = 1'b1;
                end else if (!stall_i) begin
                    w_id_bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    w_id_bubble   = 1'b1;
                    w_pc_redirect = 1'b1;
                    w_issue       = 1'b1;
                    w_issue_addr  = w_redirect;
                end else if (!stall_i) begin
                    w_id_hold    = 1'b1;
                    w_pc_inc     = 1'b1;
                    w_issue      = 1'b1;
                    w_issue_addr = w_pc_plus4;
                end
            end
            S_DROP: begin
                // The stale return is swallowed; only the PC follows a further redirect.
                w_pc_redirect = flush_i;
                w_issue       = w_ack;
                w_issue_addr  = flush_i ? w_redirect : r_pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
            r_id_pc     <= 32'h0;
            r_id_inst   <= NOP_INST;
            r_id_valid  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_imem_req  <= 1'b1;
                r_imem_addr <= w_issue_addr;
            end else if (w_req_clr) begin
                r_imem_req  <= 1'b0;
            end
            if (w_pc_redirect) r_pc <= w_redirect;
            else if (w_pc_inc) r_pc <= w_pc_plus4;
            if (w_id_fetch) begin
                r_id_pc    <= r_pc;
                r_id_inst  <= imem_data_i;
                r_id_valid <= 1'b1;
            end else if (w_id_hold) begin
                r_id_pc    <= r_hold_pc;
                r_id_inst  <= r_hold_inst;
                r_id_valid <= 1'b1;
            end else if (w_id_bubble) begin
                r_id_inst  <= NOP_INST;
                r_id_valid <= 1'b0;
            end
        end
    end

    // NOTE: the hold buffer is pure data qualified by the state, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_hold_load) begin
            r_hold_pc   <= r_pc;
            r_hold_inst <= imem_data_i;
        end
    end

    assign imem_req_o  = r_imem_req;
    assign imem_addr_o = r_imem_addr;
    assign id_pc_o     = r_id_pc;
    assign id_inst_o   = r_id_inst;
    assign id_valid_o  = r_id_valid;
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a variable-latency memory responder, a flag-based
// fetch model compared every cycle, and directed scenarios with literal expectations.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] redirect;
    logic        imem_req_o, mem_ack;
    logic [31:0] imem_addr_o, mem_data;
    logic [31:0] id_pc_o, id_inst_o;
    logic        id_valid_o;

    // second instance: reset PC at the top of the address space, memory always acking
    logic        w_req, w_ack;
    logic [31:0] w_addr, w_id_pc, w_id_inst;
    logic        w_id_valid;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .redirect_pc_i(redirect),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(mem_ack),
        .imem_data_i(mem_data), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
    );

    if_stage #(.RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .redirect_pc_i(redirect),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ack_i(w_ack),
        .imem_data_i(w_addr), .id_pc_o(w_id_pc), .id_inst_o(w_id_inst), .id_valid_o(w_id_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory: acks after cur_lat waiting cycles, data = address ^ mem_key
    int          lat_min = 0, lat_max = 0, cur_lat = 0, wait_cnt = 0;
    logic [31:0] mem_key = 32'h0;

    always @(negedge clk) begin
        #1;
        if (imem_req_o === 1'b1 && wait_cnt >= cur_lat) begin
            mem_ack  = 1'b1;
            mem_data = imem_addr_o ^ mem_key;
            wait_cnt = 0;
            cur_lat  = $urandom_range(lat_max, lat_min);
        end else if (imem_req_o === 1'b1) begin
            mem_ack  = 1'b0;
            mem_data = $urandom;
            wait_cnt++;
        end else begin
            mem_ack  = 1'b0;
            mem_data = $urandom;
            wait_cnt = 0;
        end
    end

    // reference model: what the stage must show, tracked as plain flags
    logic        m_live = 1'b0;
    logic        m_fresh, m_req, m_stale, m_held, m_id_valid, m_got;
    logic [31:0] m_pc, m_addr, m_held_inst, m_id_pc, m_id_inst;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1;  m_fresh = 1'b1;  m_req = 1'b0;  m_stale = 1'b0;  m_held = 1'b0;
            m_pc = 32'h0;   m_addr = 32'h0;  m_id_pc = 32'h0;  m_id_inst = NOP;  m_id_valid = 1'b0;
        end else if (m_live) begin
            m_got = m_req && mem_ack;
            if (m_fresh) begin
                m_fresh = 1'b0;  m_req = 1'b1;  m_addr = m_pc;
            end else if (flush) begin
                if (m_stale) begin
                    m_pc = redirect & ~32'd3;
                    if (m_got) begin m_stale = 1'b0; m_addr = m_pc; end
                end else begin
                    m_id_inst = NOP;  m_id_valid = 1'b0;  m_held = 1'b0;
                    m_pc = redirect & ~32'd3;
                    if (m_req && !m_got) m_stale = 1'b1;
                    else begin m_req = 1'b1; m_addr = m_pc; end
                end
            end else if (m_stale) begin
                if (m_got) begin m_stale = 1'b0; m_addr = m_pc; end
            end else if (m_held) begin
                if (!stall) begin
                    m_id_pc = m_pc;  m_id_inst = m_held_inst;  m_id_valid = 1'b1;
                    m_held = 1'b0;  m_pc = m_pc + 32'd4;  m_req = 1'b1;  m_addr = m_pc;
                end
            end else if (m_got) begin
                if (stall) begin
                    m_held = 1'b1;  m_held_inst = mem_data;  m_req = 1'b0;
                end else begin
                    m_id_pc = m_pc;  m_id_inst = mem_data;  m_id_valid = 1'b1;
                    m_pc = m_pc + 32'd4;  m_addr = m_pc;
                end
            end else if (!stall) begin
                m_id_inst = NOP;  m_id_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_req", imem_req_o, m_req);
            if (m_req) check("model_addr", imem_addr_o, m_addr);
            check("model_valid", id_valid_o, m_id_valid);
            check("model_pc", id_pc_o, m_id_pc);
            check("model_inst", id_inst_o, m_id_inst);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input int lo, input int hi);
        tick();
        rst = 1'b1;  stall = 1'b0;  flush = 1'b0;
        lat_min = lo;  lat_max = hi;  cur_lat = lo;
        repeat (2) tick();
        check("rst_req", imem_req_o, 1'b0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_pc", id_pc_o, 32'h0);
        check("rst_inst", id_inst_o, NOP);
        check("rst_valid", id_valid_o, 1'b0);
        check("rst_w_addr", w_addr, WRAP_PC);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found, prev_valid;
        int   nv;
        rst = 1'b1;  stall = 1'b0;  flush = 1'b0;  redirect = 32'h0;  w_ack = 1'b1;

        // zero-wait memory: one instruction per cycle; wrap instance also sees acks in IDLE
        do_reset(0, 0);
        tick();
        check("t1_req", imem_req_o, 1'b1);
        check("t1_addr", imem_addr_o, 32'h0);
        check("t1_w_req", w_req, 1'b1);
        check("t1_w_addr", w_addr, WRAP_PC);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_pc", id_pc_o, 32'(4 * k));
            check("t1_inst", id_inst_o, 32'(4 * k));
            check("t1_valid", id_valid_o, 1'b1);
            if (k == 0) check("t1_w_pc_top", w_id_pc, WRAP_PC);
            if (k == 1) check("t1_w_pc_wrap", w_id_pc, 32'h0);
            if (k == 1) check("t1_w_inst_wrap", w_id_inst, 32'h0);
            if (k == 1) check("t1_w_valid", w_id_valid, 1'b1);
        end

        // 3 waiting cycles per fetch: isolated valid pulses, PCs in order
        do_reset(3, 3);
        nv = 0;  prev_valid = 1'b0;
        for (int c = 0; c < 13; c++) begin
            tick();
            if (id_valid_o) begin
                check("t2_pc", id_pc_o, 32'(4 * nv));
                check("t2_single_pulse", prev_valid, 1'b0);
                nv++;
            end else begin
                check("t2_bubble", id_inst_o, NOP);
            end
            prev_valid = id_valid_o;
        end
        check("t2_count", nv, 3);

        // stall for 4 cycles while PC 8 returns
        do_reset(0, 0);
        repeat (3) tick();
        check("t3_pc4", id_pc_o, 32'h4);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_frozen_pc", id_pc_o, 32'h4);
            check("t3_frozen_valid", id_valid_o, 1'b1);
            if (i == 0) check("t3_req_dropped", imem_req_o, 1'b0);
        end
        stall = 1'b0;
        tick();
        check("t3_pc8", id_pc_o, 32'h8);
        check("t3_inst8", id_inst_o, 32'h8);
        check("t3_req12", imem_req_o, 1'b1);
        check("t3_addr12", imem_addr_o, 32'hC);
        tick();
        check("t3_pc12", id_pc_o, 32'hC);

        // flush while the PC 8 fetch is still pending
        do_reset(3, 3);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (id_valid_o && id_pc_o == 32'h4) found = 1'b1;
        end
        check("t4_pc4_seen", found, 1'b1);
        tick();
        flush = 1'b1;  redirect = 32'h100;
        tick();
        flush = 1'b0;
        check("t4_drop_req", imem_req_o, 1'b1);
        check("t4_drop_addr", imem_addr_o, 32'h8);
        check("t4_drop_valid", id_valid_o, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (id_valid_o) begin
                found = 1'b1;
                check("t4_first_pc", id_pc_o, 32'h100);
                check("t4_first_inst", id_inst_o, 32'h100);
            end
        end
        check("t4_valid_seen", found, 1'b1);

        // flush and stall together while holding; misaligned redirect
        do_reset(0, 0);
        repeat (3) tick();
        stall = 1'b1;
        tick();
        check("t5_hold_req", imem_req_o, 1'b0);
        flush = 1'b1;  redirect = 32'h103;
        tick();
        flush = 1'b0;  stall = 1'b0;
        check("t5_bubble_valid", id_valid_o, 1'b0);
        check("t5_bubble_inst", id_inst_o, NOP);
        check("t5_req", imem_req_o, 1'b1);
        check("t5_addr", imem_addr_o, 32'h100);
        tick();
        check("t5_pc", id_pc_o, 32'h100);
        check("t5_valid", id_valid_o, 1'b1);
        tick();
        check("t5_next_pc", id_pc_o, 32'h104);

        // randomized traffic against the model
        mem_key = $urandom;
        do_reset(0, 3);
        for (int c = 0; c < 3000; c++) begin
            tick();
            stall = ($urandom_range(99) < 25);
            flush = ($urandom_range(99) < 6);
            if ($urandom_range(3) == 0) redirect = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else                        redirect = $urandom;
        end

        // reset in the middle of an outstanding request
        tick();
        stall = 1'b0;  flush = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req_o) found = 1'b1;
        end
        check("t6_req_seen", found, 1'b1);
        rst = 1'b1;
        tick();
        check("t6_req", imem_req_o, 1'b0);
        check("t6_addr", imem_addr_o, 32'h0);
        check("t6_pc", id_pc_o, 32'h0);
        check("t6_inst", id_inst_o, NOP);
        check("t6_valid", id_valid_o, 1'b0);
        rst = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
